// File: rtl/ms6205_write_sequencer_if.sv
// Request and display-bus signal bundle for the MS6205 write sequencer.
// The slave modport is the sequencer; the master is the upstream/refresh side.
interface ms6205_write_sequencer_if;
  logic        req_valid;
  logic [7:0]  req_addr;
  logic [7:0]  req_data;
  logic        req_ready;
  logic [7:0]  ms6205_addr;
  logic [7:0]  ms6205_data_n;
  logic        ms6205_addr_acq;
  logic        ms6205_data_acq;
  logic        busy;
  logic [15:0] write_count;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, ms6205_addr, ms6205_data_n, ms6205_addr_acq, ms6205_data_acq,
    input  busy, write_count
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, ms6205_addr, ms6205_data_n, ms6205_addr_acq, ms6205_data_acq,
    output busy, write_count
  );
endinterface

// File: rtl/ms6205_write_sequencer.sv
// MS6205 physical write stage: request FIFO feeding a timed address-strobe /
// data-strobe sequence on the display bus, with a completed-write counter.
module ms6205_write_sequencer #(
  parameter int SETUP_CYC  = 4,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  ms6205_write_sequencer_if.slave bus
);
  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int TW = $clog2(MAX_CYC) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] T_SETUP  = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] T_STROBE = TW'(STROBE_CYC - 1);
  localparam logic [TW-1:0] T_HOLD   = TW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A_SETUP  = 3'd1,
    A_STROBE = 3'd2,
    D_SETUP  = 3'd3,
    D_STROBE = 3'd4,
    HOLD     = 3'd5
  } state_e;

  logic [7:0]    fifo_addr_q [FIFO_DEPTH];
  logic [7:0]    fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          push_s, pop_s, empty_s;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_n_q, data_n_d;
  logic          addr_acq_q, addr_acq_d;
  logic          data_acq_q, data_acq_d;
  logic          busy_q, busy_d;
  logic [15:0]   wc_q, wc_d;

  assign empty_s = (count_q == {CW{1'b0}});
  assign push_s  = bus.req_valid && !full_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop_s   = 1'b0;
    wc_d    = wc_q;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = A_SETUP;
          timer_d = T_SETUP;
        end else begin
          timer_d = timer_q;
        end
      end
      A_SETUP: begin
        if (timer_q == {TW{1'b0}}) begin
          state_d = A_STROBE;
          timer_d = T_STROBE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      A_STROBE: begin
        if (timer_q == {TW{1'b0}}) begin
          state_d = D_SETUP;
          timer_d = T_SETUP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      D_SETUP: begin
        if (timer_q == {TW{1'b0}}) begin
          state_d = D_STROBE;
          timer_d = T_STROBE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      D_STROBE: begin
        if (timer_q == {TW{1'b0}}) begin
          state_d = HOLD;
          timer_d = T_HOLD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      HOLD: begin
        if (timer_q == {TW{1'b0}}) begin
          wc_d = wc_q + 16'd1;
          // Streaming: reload straight from the FIFO without an IDLE cycle.
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_d = A_SETUP;
            timer_d = T_SETUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = {TW{1'b0}};
      end
    endcase

    if (pop_s) begin
      addr_d   = fifo_addr_q[rd_ptr_q];
      data_n_d = ~fifo_data_q[rd_ptr_q];
    end else begin
      addr_d   = addr_q;
      data_n_d = data_n_q;
    end

    count_d    = count_q + CW'(push_s) - CW'(pop_s);
    full_d     = (count_d == DEPTH_C);
    // Strobes are decoded from the next state so the flops drive them glitch-free.
    addr_acq_d = (state_d != A_STROBE);
    data_acq_d = (state_d != D_STROBE);
    busy_d     = (count_d != {CW{1'b0}}) || (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= bus.req_addr;
      fifo_data_q[wr_ptr_q] <= bus.req_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      full_q     <= 1'b0;
      state_q    <= IDLE;
      timer_q    <= {TW{1'b0}};
      addr_q     <= 8'h00;
      data_n_q   <= 8'hFF;
      addr_acq_q <= 1'b1;
      data_acq_q <= 1'b1;
      busy_q     <= 1'b0;
      wc_q       <= 16'h0000;
    end else begin
      wr_ptr_q   <= push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_q   <= pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      count_q    <= count_d;
      full_q     <= full_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      data_n_q   <= data_n_d;
      addr_acq_q <= addr_acq_d;
      data_acq_q <= data_acq_d;
      busy_q     <= busy_d;
      wc_q       <= wc_d;
    end
  end

  assign bus.req_ready       = ~full_q;
  assign bus.ms6205_addr     = addr_q;
  assign bus.ms6205_data_n   = data_n_q;
  assign bus.ms6205_addr_acq = addr_acq_q;
  assign bus.ms6205_data_acq = data_acq_q;
  assign bus.busy            = busy_q;
  assign bus.write_count     = wc_q;
endmodule

// File: tb/tb_ms6205_write_sequencer.sv
// Self-checking bench for ms6205_write_sequencer: per-scenario tasks compared
// against a timeline model (word start edge + offset arithmetic).
module tb_ms6205_write_sequencer;
  localparam int S  = 4;
  localparam int ST = 8;
  localparam int H  = 4;
  localparam int D  = 4;
  localparam int P  = 2*S + 2*ST + H;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  ms6205_write_sequencer_if bus();

  ms6205_write_sequencer #(
    .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H), .FIFO_DEPTH(D)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model: pending words with their accept edge, plus the word on the bus and its start edge.
  int          e = 0;
  logic [7:0]  qa[$];
  logic [7:0]  qd[$];
  int          qt[$];
  bit          act_v = 1'b0;
  int          act_start = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [7:0]  m_data_n = 8'hFF;
  logic [15:0] m_wc = 16'h0000;
  bit          m_acc = 1'b0;

  task automatic model_edge();
    int n_before;
    e++;
    m_acc = 1'b0;
    if (Rst) begin
      qa.delete(); qd.delete(); qt.delete();
      act_v = 1'b0; m_addr = 8'h00; m_data_n = 8'hFF; m_wc = 16'h0000;
    end else begin
      n_before = qa.size();
      if (act_v && e == act_start + P) begin
        act_v = 1'b0;
        m_wc  = m_wc + 16'd1;
      end
      if (!act_v && qa.size() != 0 && qt[0] < e) begin
        m_addr   = qa.pop_front();
        m_data_n = ~qd.pop_front();
        void'(qt.pop_front());
        act_v     = 1'b1;
        act_start = e;
      end
      if (bus.req_valid && n_before < D) begin
        qa.push_back(bus.req_addr);
        qd.push_back(bus.req_data);
        qt.push_back(e);
        m_acc = 1'b1;
      end
    end
  endtask

  function automatic logic [35:0] exp_vec();
    int off = e - act_start;
    logic aa, da;
    aa = !(act_v && off >= S && off < S + ST);
    da = !(act_v && off >= 2*S + ST && off < 2*(S + ST));
    return {(qa.size() < D), m_addr, m_data_n, aa, da, (act_v || qa.size() != 0), m_wc};
  endfunction

  function automatic logic [35:0] obs_vec();
    return {bus.req_ready, bus.ms6205_addr, bus.ms6205_data_n, bus.ms6205_addr_acq,
            bus.ms6205_data_acq, bus.busy, bus.write_count};
  endfunction

  task automatic step();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    bus.req_valid = 1'b0;
    step();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    bus.req_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (obs_vec() !== {1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs_vec(),
               {1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 16'h0000});
    end
    Rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec() || {bus.ms6205_addr_acq, bus.ms6205_data_acq} !== 2'b11) begin
        errors++;
        $display("FAIL idle_after_reset edge %0d: got %h expected %h", e, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    int a_low = 0, d_low = 0, a_first = -1, d_first = -1, wc_at = -1;
    do_reset();
    bus.req_valid = 1'b1; bus.req_addr = 8'h05; bus.req_data = 8'h41;
    step();
    bus.req_valid = 1'b0;
    step();
    checks++;
    if ({bus.ms6205_addr, bus.ms6205_data_n} !== 16'h05BE) begin
      errors++;
      $display("FAIL single_load: got %h expected 05be", {bus.ms6205_addr, bus.ms6205_data_n});
    end
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_vec edge %0d: got %h expected %h", e, obs_vec(), exp_vec());
      end
      if (!bus.ms6205_addr_acq) begin a_low++; if (a_first < 0) a_first = i; end
      if (!bus.ms6205_data_acq) begin d_low++; if (d_first < 0) d_first = i; end
      if (bus.write_count == 16'd1 && wc_at < 0) wc_at = i;
    end
    checks++;
    if (a_low != ST || d_low != ST || a_first != S || d_first != 2*S + ST || wc_at != P) begin
      errors++;
      $display("FAIL single_timing: got alow=%0d dlow=%0d afirst=%0d dfirst=%0d wc_at=%0d expected %0d %0d %0d %0d %0d",
               a_low, d_low, a_first, d_first, wc_at, ST, ST, S, 2*S + ST, P);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.write_count !== 16'd1) begin
      errors++;
      $display("FAIL single_end: got busy=%b wc=%0d expected busy=0 wc=1", bus.busy, bus.write_count);
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0, n = 0;
    int falls[$];
    logic [7:0] fa[$];
    bit prev_a = 1'b1, saw_full = 1'b0;
    do_reset();
    while ((idx < 6 || bus.busy) && n < 400) begin
      bus.req_valid = (idx < 6);
      bus.req_addr  = 8'(idx);
      bus.req_data  = 8'($urandom);
      step();
      n++;
      if (m_acc) idx++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_vec edge %0d: got %h expected %h", e, obs_vec(), exp_vec());
      end
      if (!bus.req_ready) saw_full = 1'b1;
      if (prev_a && !bus.ms6205_addr_acq) begin falls.push_back(e); fa.push_back(bus.ms6205_addr); end
      prev_a = bus.ms6205_addr_acq;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (falls.size() != 6 || bus.write_count !== 16'd6 || !saw_full) begin
      errors++;
      $display("FAIL b2b_count: got writes=%0d wc=%0d full_seen=%0d expected 6 6 1",
               falls.size(), bus.write_count, saw_full);
    end
    for (int i = 0; i < falls.size(); i++) begin
      checks++;
      if (fa[i] !== 8'(i) || (i > 0 && falls[i] - falls[i-1] != P)) begin
        errors++;
        $display("FAIL b2b_order word %0d: got addr=%h gap=%0d expected addr=%h gap=%0d",
                 i, fa[i], (i > 0) ? falls[i] - falls[i-1] : P, 8'(i), P);
      end
    end
  endtask

  task automatic test_full_pop();
    int idx = 0, n = 0;
    logic [7:0] sa[8];
    logic [7:0] sd[8];
    logic [7:0] fa[$];
    logic [7:0] fd[$];
    bit prev_a = 1'b1;
    for (int i = 0; i < 8; i++) begin sa[i] = 8'($urandom); sd[i] = 8'($urandom); end
    do_reset();
    while ((idx < 8 || bus.busy) && n < 600) begin
      bus.req_valid = (idx < 8);
      bus.req_addr  = sa[idx % 8];
      bus.req_data  = sd[idx % 8];
      step();
      n++;
      if (m_acc) idx++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fullpop_vec edge %0d: got %h expected %h", e, obs_vec(), exp_vec());
      end
      if (prev_a && !bus.ms6205_addr_acq) begin
        fa.push_back(bus.ms6205_addr);
        fd.push_back(~bus.ms6205_data_n);
      end
      prev_a = bus.ms6205_addr_acq;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (fa.size() != 8 || bus.write_count !== 16'd8) begin
      errors++;
      $display("FAIL fullpop_count: got writes=%0d wc=%0d expected 8 8", fa.size(), bus.write_count);
    end
    for (int i = 0; i < fa.size() && i < 8; i++) begin
      checks++;
      if ({fa[i], fd[i]} !== {sa[i], sd[i]}) begin
        errors++;
        $display("FAIL fullpop_word %0d: got %h expected %h", i, {fa[i], fd[i]}, {sa[i], sd[i]});
      end
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0, n = 0, nfalls = 0;
    bit prev_a = 1'b1;
    do_reset();
    while (nfalls < 2 && n < 200) begin
      bus.req_valid = (idx < 4);
      bus.req_addr  = 8'($urandom_range(0, 159));
      bus.req_data  = 8'($urandom);
      step();
      n++;
      if (m_acc) idx++;
      if (prev_a && !bus.ms6205_addr_acq) nfalls++;
      prev_a = bus.ms6205_addr_acq;
    end
    bus.req_valid = 1'b0;
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    checks++;
    if (nfalls != 2 || obs_vec() !== {1'b1, bus.ms6205_addr, bus.ms6205_data_n, 1'b1, 1'b1, 1'b0, 16'h0000}
        || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL midreset_abort: got falls=%0d vec=%h expected falls=2 vec=%h", nfalls, obs_vec(), exp_vec());
    end
    for (int i = 0; i < 40; i++) begin
      bus.req_valid = (i == 5);
      bus.req_addr  = 8'h9F;
      bus.req_data  = 8'h5A;
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL midreset_after edge %0d: got %h expected %h", e, obs_vec(), exp_vec());
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (bus.write_count !== 16'd1 || {bus.ms6205_addr, bus.ms6205_data_n} !== 16'h9FA5) begin
      errors++;
      $display("FAIL midreset_newreq: got wc=%0d bus=%h expected wc=1 bus=9fa5",
               bus.write_count, {bus.ms6205_addr, bus.ms6205_data_n});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.wc_q = 16'hFFFF;
    #1;
    release dut.wc_q;
    m_wc = 16'hFFFF;
    checks++;
    if (bus.write_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h expected ffff", bus.write_count);
    end
    for (int i = 0; i < 40; i++) begin
      bus.req_valid = (i == 0);
      bus.req_addr  = 8'($urandom);
      bus.req_data  = 8'($urandom);
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_vec edge %0d: got %h expected %h", e, obs_vec(), exp_vec());
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (bus.write_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_final: got %h expected 0000", bus.write_count);
    end
  endtask

  task automatic test_random();
    int n = 0;
    do_reset();
    for (int i = 0; i < 700 || (bus.busy && n < 300); i++) begin
      if (i >= 700) n++;
      bus.req_valid = (i < 700) && ($urandom_range(0, 5) == 0);
      bus.req_addr  = 8'($urandom);
      bus.req_data  = 8'($urandom);
      step();
      checks++;
      if (obs_vec() !== exp_vec() || (!bus.ms6205_addr_acq && !bus.ms6205_data_acq)) begin
        errors++;
        $display("FAIL random_vec edge %0d: got %h expected %h", e, obs_vec(), exp_vec());
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got busy=%b expected 0", bus.busy);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
